ifetch: RTL

IFETCH -- requirements
Module: ifetch

---
 rtl/riscv_pkg.sv | 18 +
 rtl/ifetch_buf.sv | 69 ++++++
 rtl/ifetch.sv | 86 ++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared core constants and types used by the fetch stage.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~{{(XLEN-2){1'b0}}, 2'b11};
    endfunction

endpackage

// File: rtl/ifetch_buf.sv
// Two-entry instruction/PC buffer between the memory response and decode.
module ifetch_buf
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic [XLEN-1:0] push_instr_i,
    input  logic [XLEN-1:0] push_pc_i,
    input  logic            pop_i,
    output logic [1:0]      count_o,
    output logic            valid_o,
    output logic [XLEN-1:0] head_instr_o,
    output logic [XLEN-1:0] head_pc_o
);

    fetch_entry_t    mem_q [2];
    fetch_entry_t    mem_d [2];
    logic            head_q, head_d;
    logic [1:0]      count_q, count_d;
    logic [XLEN-1:0] last_pc_q, last_pc_d;
    logic            tail;

    assign valid_o      = (count_q != 2'd0);
    assign count_o      = count_q;
    assign head_instr_o = valid_o ? mem_q[head_q].instr : NOP_INSTR;
    assign head_pc_o    = valid_o ? mem_q[head_q].pc    : last_pc_q;

    always_comb begin
        // With one entry the tail is the other slot; with zero or two it is the head slot.
        tail      = head_q ^ count_q[0];
        mem_d     = mem_q;
        head_d    = head_q;
        count_d   = count_q;
        last_pc_d = valid_o ? mem_q[head_q].pc : last_pc_q;
        if (flush_i) begin
            head_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push_i) begin
                mem_d[tail] = '{instr: push_instr_i, pc: push_pc_i};
            end
            if (pop_i) begin
                head_d = ~head_q;
            end
            count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q    <= 1'b0;
            count_q   <= 2'd0;
            last_pc_q <= RESET_PC;
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
        end else begin
            head_q    <= head_d;
            count_q   <= count_d;
            last_pc_q <= last_pc_d;
            mem_q     <= mem_d;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: fetch PC, single-cycle memory request tracking and
// the decode-facing instruction buffer.
module ifetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int              BUF_DEPTH = 2
)
(
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            id_ready_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_instr_o,
    output logic [XLEN-1:0] if_pc_o
);

    localparam logic [2:0] DEPTH_L = 3'(BUF_DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic [1:0]      buf_count;
    logic            buf_valid;
    logic [XLEN-1:0] buf_instr;
    logic [XLEN-1:0] buf_pc;
    logic            pop;
    logic [2:0]      occupancy;
    logic            req;

    always_comb begin
        pop = buf_valid & id_ready_i & ~rst_i;
        // A slot freed by this cycle's pop is already available, which keeps
        // delivery at one instruction per cycle while decode is ready.
        occupancy     = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
        req           = ~rst_i & ~redirect_i & (occupancy < DEPTH_L);
        inflight_d    = req;
        inflight_pc_d = align_pc(fetch_pc_q);
        fetch_pc_d    = fetch_pc_q;
        if (redirect_i) begin
            fetch_pc_d = align_pc(redirect_pc_i);
        end else if (req) begin
            fetch_pc_d = align_pc(fetch_pc_q) + XLEN'(4);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    ifetch_buf #(
        .RESET_PC (RESET_PC)
    ) u_buf (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (redirect_i),
        .push_i       (inflight_q),
        .push_instr_i (imem_data_i),
        .push_pc_i    (inflight_pc_q),
        .pop_i        (pop),
        .count_o      (buf_count),
        .valid_o      (buf_valid),
        .head_instr_o (buf_instr),
        .head_pc_o    (buf_pc)
    );

    assign imem_req_o  = req;
    assign imem_addr_o = align_pc(fetch_pc_q);
    assign if_valid_o  = buf_valid & ~rst_i;
    assign if_instr_o  = rst_i ? NOP_INSTR : buf_instr;
    assign if_pc_o     = rst_i ? RESET_PC  : buf_pc;

endmodule
